// File: rtl/switch_frame_sync_if.sv
// Switch/frame-sync bundle: raw switches and vsync in, frame-aligned value out.
// Pure wiring, no latency.
// No backpressure: levels and single-cycle pulses only.
interface switch_frame_sync_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw_in;
    logic             vsync;
    logic [WIDTH-1:0] value;
    logic             value_changed;
    logic             pending;

    modport master (
        output sw_in,
        output vsync,
        input  value,
        input  value_changed,
        input  pending
    );

    modport slave (
        input  sw_in,
        input  vsync,
        output value,
        output value_changed,
        output pending
    );
endinterface

// File: rtl/switch_frame_sync.sv
// Synchronizes and debounces slide switches, then publishes them only at the vsync falling edge.
// Latency: 2-flop sync + DEBOUNCE_CYCLES to accept, then 3 cycles after the next vsync fall.
// No backpressure: a newer accepted pattern silently replaces an unpublished one.
module switch_frame_sync #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk_fpga,
    input  logic                reset,
    switch_frame_sync_if.slave  sw_bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_s1;
    logic [WIDTH-1:0] sw_s2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] value_q;
    logic [CNT_W-1:0] cnt;
    logic             vs_s1;
    logic             vs_s2;
    logic             vs_d;
    logic             value_changed_q;
    logic             vs_fall;
    logic             pending_w;

    assign vs_fall   = vs_d & ~vs_s2;
    assign pending_w = (stable != value_q);

    // vsync flops reset high so releasing reset never fakes a sync edge
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_d  <= 1'b1;
        end else begin
            sw_s1 <= sw_bus.sw_in;
            sw_s2 <= sw_s1;
            vs_s1 <= sw_bus.vsync;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    // Whole-vector debounce: any bit change restarts the count; counter saturates
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else if (sw_s2 != cand) begin
            cand <= sw_s2;
            cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
            stable <= cand;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Publish reads stable before this edge's update, so a colliding accept waits a frame
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            value_q         <= '0;
            value_changed_q <= 1'b0;
        end else begin
            value_changed_q <= vs_fall & pending_w;
            if (vs_fall && pending_w) begin
                value_q <= stable;
            end
        end
    end

    assign sw_bus.value         = value_q;
    assign sw_bus.value_changed = value_changed_q;
    assign sw_bus.pending       = pending_w;

endmodule

// File: tb/tb_switch_frame_sync.sv
// Directed bench for switch_frame_sync with DEBOUNCE_CYCLES=8 and hand-driven vsync pulses.
module tb_switch_frame_sync;

    logic clk;
    logic reset;

    int checks;
    int errors;
    int vc_cnt;
    int seen3_cnt;

    logic [3:0] fv2;
    logic       fc2;
    logic [3:0] fv3;
    logic       fc3;
    logic       fc4;

    switch_frame_sync_if #(.WIDTH(4)) bus ();

    switch_frame_sync #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_fpga(clk),
        .reset(reset),
        .sw_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.value_changed === 1'b1) vc_cnt++;
        if (bus.value === 4'h3) seen3_cnt++;
    end

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // vsync low for 4 cycles; samples value/value_changed 2, 3 and 4 edges after the drop
    task automatic frame();
        bus.vsync = 1'b0;
        step_n(2);
        fv2 = bus.value;
        fc2 = bus.value_changed;
        step_n(1);
        fv3 = bus.value;
        fc3 = bus.value_changed;
        step_n(1);
        fc4 = bus.value_changed;
        bus.vsync = 1'b1;
        step_n(4);
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b0;
        bus.sw_in = 4'hF;
        bus.vsync = 1'b1;
        step_n(3);
        checks++; if (bus.value !== 4'h0) begin errors++; $display("FAIL reset_value: got %h expected %h", bus.value, 4'h0); end
        checks++; if (bus.value_changed !== 1'b0) begin errors++; $display("FAIL reset_value_changed: got %b expected %b", bus.value_changed, 1'b0); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b expected %b", bus.pending, 1'b0); end
        base = vc_cnt;
        reset = 1'b1;
        step_n(12);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL reset_accept_pending: got %b expected %b", bus.pending, 1'b1); end
        checks++; if (bus.value !== 4'h0) begin errors++; $display("FAIL reset_hold_value: got %h expected %h", bus.value, 4'h0); end
        checks++; if (vc_cnt - base !== 0) begin errors++; $display("FAIL reset_no_early_pulse: got %0d expected %0d", vc_cnt - base, 0); end
        frame();
        checks++; if (fv2 !== 4'h0 || fc2 !== 1'b0) begin errors++; $display("FAIL reset_frame_early: got value %h vc %b expected 0 0", fv2, fc2); end
        checks++; if (fv3 !== 4'hF || fc3 !== 1'b1) begin errors++; $display("FAIL reset_frame_publish: got value %h vc %b expected f 1", fv3, fc3); end
        checks++; if (fc4 !== 1'b0) begin errors++; $display("FAIL reset_pulse_width: got %b expected %b", fc4, 1'b0); end
        checks++; if (vc_cnt - base !== 1) begin errors++; $display("FAIL reset_pulse_count: got %0d expected %0d", vc_cnt - base, 1); end
        bus.sw_in = 4'h0;
        step_n(12);
        frame();
        checks++; if (fv3 !== 4'h0) begin errors++; $display("FAIL reset_return_zero: got %h expected %h", fv3, 4'h0); end
    endtask

    task automatic test_clean_change();
        bus.sw_in = 4'h5;
        step_n(10);
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL clean_pending_early: got %b expected %b", bus.pending, 1'b0); end
        step_n(1);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL clean_pending_rise: got %b expected %b", bus.pending, 1'b1); end
        step_n(20);
        checks++; if (bus.value !== 4'h0) begin errors++; $display("FAIL clean_value_hold: got %h expected %h", bus.value, 4'h0); end
        frame();
        checks++; if (fv2 !== 4'h0 || fc2 !== 1'b0) begin errors++; $display("FAIL clean_frame_early: got value %h vc %b expected 0 0", fv2, fc2); end
        checks++; if (fv3 !== 4'h5 || fc3 !== 1'b1) begin errors++; $display("FAIL clean_publish: got value %h vc %b expected 5 1", fv3, fc3); end
        checks++; if (fc4 !== 1'b0) begin errors++; $display("FAIL clean_pulse_width: got %b expected %b", fc4, 1'b0); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL clean_pending_drop: got %b expected %b", bus.pending, 1'b0); end
    endtask

    task automatic test_bounce();
        int base;
        int bad;
        base = vc_cnt;
        bad = 0;
        for (int i = 0; i < 13; i++) begin
            bus.sw_in = (i % 2 == 0) ? 4'h1 : 4'h0;
            if (i == 6) bus.vsync = 1'b0;
            if (i == 8) bus.vsync = 1'b1;
            for (int j = 0; j < 3; j++) begin
                step_n(1);
                if (bus.pending !== 1'b0 || bus.value !== 4'h5) bad++;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bounce_stable: got %0d disturbed cycles expected %0d", bad, 0); end
        checks++; if (vc_cnt - base !== 0) begin errors++; $display("FAIL bounce_no_pulse: got %0d expected %0d", vc_cnt - base, 0); end
        step_n(3);
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL bounce_quiet_early: got %b expected %b", bus.pending, 1'b0); end
        step_n(6);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL bounce_accept: got %b expected %b", bus.pending, 1'b1); end
        frame();
        checks++; if (fv3 !== 4'h1 || fc3 !== 1'b1) begin errors++; $display("FAIL bounce_publish: got value %h vc %b expected 1 1", fv3, fc3); end
    endtask

    task automatic test_two_patterns();
        int base;
        int base3;
        base = vc_cnt;
        base3 = seen3_cnt;
        bus.sw_in = 4'h3;
        step_n(20);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL two_first_pending: got %b expected %b", bus.pending, 1'b1); end
        bus.sw_in = 4'h9;
        step_n(20);
        frame();
        checks++; if (fv3 !== 4'h9 || fc3 !== 1'b1) begin errors++; $display("FAIL two_publish_last: got value %h vc %b expected 9 1", fv3, fc3); end
        checks++; if (vc_cnt - base !== 1) begin errors++; $display("FAIL two_pulse_count: got %0d expected %0d", vc_cnt - base, 1); end
        checks++; if (seen3_cnt - base3 !== 0) begin errors++; $display("FAIL two_no_intermediate: got %0d cycles of 3 expected %0d", seen3_cnt - base3, 0); end
    endtask

    task automatic test_collision();
        bus.sw_in = 4'hB;
        step_n(12);
        bus.sw_in = 4'hA;
        // stable takes 4'hA 11 edges after the change; vsync dropped after edge 8 publishes at edge 11
        step_n(8);
        frame();
        checks++; if (fv2 !== 4'h9) begin errors++; $display("FAIL collide_before: got %h expected %h", fv2, 4'h9); end
        checks++; if (fv3 !== 4'hB || fc3 !== 1'b1) begin errors++; $display("FAIL collide_old_stable: got value %h vc %b expected b 1", fv3, fc3); end
        checks++; if (bus.pending !== 1'b1 || bus.value !== 4'hB) begin errors++; $display("FAIL collide_pending: got pending %b value %h expected 1 b", bus.pending, bus.value); end
        frame();
        checks++; if (fv3 !== 4'hA || fc3 !== 1'b1) begin errors++; $display("FAIL collide_next_frame: got value %h vc %b expected a 1", fv3, fc3); end
        checks++; if (bus.pending !== 1'b0) begin errors++; $display("FAIL collide_pending_drop: got %b expected %b", bus.pending, 1'b0); end
    endtask

    task automatic test_reset_mid();
        int base;
        bus.sw_in = 4'hC;
        step_n(12);
        checks++; if (bus.pending !== 1'b1) begin errors++; $display("FAIL rmid_pre_pending: got %b expected %b", bus.pending, 1'b1); end
        bus.sw_in = 4'hD;
        step_n(6);
        #2;
        reset = 1'b0;
        bus.vsync = 1'b0;
        #1;
        checks++; if (bus.value !== 4'h0 || bus.value_changed !== 1'b0 || bus.pending !== 1'b0) begin
            errors++; $display("FAIL rmid_async_clear: got value %h vc %b pending %b expected 0 0 0", bus.value, bus.value_changed, bus.pending);
        end
        step_n(2);
        base = vc_cnt;
        reset = 1'b1;
        step_n(6);
        checks++; if (vc_cnt - base !== 0 || bus.value !== 4'h0) begin errors++; $display("FAIL rmid_no_spurious: got pulses %0d value %h expected 0 0", vc_cnt - base, bus.value); end
        step_n(8);
        checks++; if (bus.pending !== 1'b1 || bus.value !== 4'h0) begin errors++; $display("FAIL rmid_hold_low: got pending %b value %h expected 1 0", bus.pending, bus.value); end
        bus.vsync = 1'b1;
        step_n(4);
        frame();
        checks++; if (fv3 !== 4'hD || fc3 !== 1'b1) begin errors++; $display("FAIL rmid_publish: got value %h vc %b expected d 1", fv3, fc3); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vc_cnt = 0;
        seen3_cnt = 0;
        test_reset();
        test_clean_change();
        test_bounce();
        test_two_patterns();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
